// File: rtl/c5x7_pkg.sv
// Shared constants, window types and the host-address range check
// for the c5x7 convolution front end.
package c5x7_pkg;
   localparam int ROWS  = 7;
   localparam int COLS  = 5;
   localparam int NSAMP = ROWS * COLS;
   localparam int SW    = 40;
   localparam int WAW   = 6;
   localparam int WDW   = 33;
   localparam int WMAX  = 34;

   typedef logic signed [SW-1:0]       samp_t;
   typedef samp_t [ROWS-1:0][COLS-1:0] win_t;
   typedef logic [2:0]                 idx_t;

   localparam idx_t LAST_ROW = idx_t'(ROWS - 1);
   localparam idx_t LAST_COL = idx_t'(COLS - 1);

   function automatic logic waddr_ok(input logic [WAW-1:0] addr);
      return addr <= WAW'(WMAX);
   endfunction
endpackage

// File: rtl/c5x7_wcfg.sv
// Host weight-write path: range check, one register stage onto the core's
// cw/ca/cd port, and a saturating count of rejected writes.
module c5x7_wcfg
   import c5x7_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           i_h_cw,
   input  logic [WAW-1:0] i_h_ca,
   input  logic [WDW-1:0] i_h_cd,
   output logic           o_cw,
   output logic [WAW-1:0] o_ca,
   output logic [WDW-1:0] o_cd,
   output logic [7:0]     o_drop_cnt
);
   logic           w_accept;
   logic           w_reject;
   logic           r_cw;
   logic [WAW-1:0] r_ca;
   logic [WDW-1:0] r_cd;
   logic [7:0]     r_drop_cnt;

   assign w_accept = i_h_cw &  waddr_ok(i_h_ca);
   assign w_reject = i_h_cw & ~waddr_ok(i_h_ca);

   // Address and data are forced to zero whenever no write is issued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cw       <= 1'b0;
         r_ca       <= '0;
         r_cd       <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_cw <= w_accept;
         r_ca <= w_accept ? i_h_ca : '0;
         r_cd <= w_accept ? i_h_cd : '0;
         if (w_reject && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   assign o_cw       = r_cw;
   assign o_ca       = r_ca;
   assign o_cd       = r_cd;
   assign o_drop_cnt = r_drop_cnt;
endmodule

// File: rtl/c5x7_win_feeder.sv
// Assembles a serial sample stream into a 7x5 window for the c5x7 core and
// registers host weight writes with the same one-cycle latency.
module c5x7_win_feeder
   import c5x7_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           push_in,
   input  logic [SW-1:0]  samp_in,
   input  logic           slide,
   input  logic           flush,
   input  logic           h_cw,
   input  logic [WAW-1:0] h_ca,
   input  logic [WDW-1:0] h_cd,
   output logic           push_samp,
   output logic [SW-1:0]  samp00,
   output logic [SW-1:0]  samp01,
   output logic [SW-1:0]  samp02,
   output logic [SW-1:0]  samp03,
   output logic [SW-1:0]  samp04,
   output logic [SW-1:0]  samp10,
   output logic [SW-1:0]  samp11,
   output logic [SW-1:0]  samp12,
   output logic [SW-1:0]  samp13,
   output logic [SW-1:0]  samp14,
   output logic [SW-1:0]  samp20,
   output logic [SW-1:0]  samp21,
   output logic [SW-1:0]  samp22,
   output logic [SW-1:0]  samp23,
   output logic [SW-1:0]  samp24,
   output logic [SW-1:0]  samp30,
   output logic [SW-1:0]  samp31,
   output logic [SW-1:0]  samp32,
   output logic [SW-1:0]  samp33,
   output logic [SW-1:0]  samp34,
   output logic [SW-1:0]  samp40,
   output logic [SW-1:0]  samp41,
   output logic [SW-1:0]  samp42,
   output logic [SW-1:0]  samp43,
   output logic [SW-1:0]  samp44,
   output logic [SW-1:0]  samp50,
   output logic [SW-1:0]  samp51,
   output logic [SW-1:0]  samp52,
   output logic [SW-1:0]  samp53,
   output logic [SW-1:0]  samp54,
   output logic [SW-1:0]  samp60,
   output logic [SW-1:0]  samp61,
   output logic [SW-1:0]  samp62,
   output logic [SW-1:0]  samp63,
   output logic [SW-1:0]  samp64,
   output logic           cw,
   output logic [WAW-1:0] ca,
   output logic [WDW-1:0] cd,
   output logic [7:0]     drop_cnt
);
   win_t r_fill;
   win_t r_hold;
   idx_t r_row;
   idx_t r_col;
   logic r_push;

   win_t w_win;
   win_t w_shift;
   logic w_take;
   logic w_last;

   assign w_take = push_in & ~flush;
   assign w_last = w_take & (r_row == LAST_ROW) & (r_col == LAST_COL);

   // w_win is the fill buffer as it will look once this cycle's sample lands,
   // so the completing sample reaches the holding registers on the same edge.
   // NOTE: combinational blocks use blocking '=' and give every target a
   // default first; the later partial overrides then cannot infer a latch.
   always_comb begin
      w_win                = r_fill;
      w_win[r_row][r_col]  = samp_in;
      w_shift              = w_win;
      for (int r = 0; r < ROWS - 1; r++) begin
         w_shift[r] = w_win[r+1];
      end
   end

   // NOTE: state flops use non-blocking '<=' so every register samples the
   // pre-edge values. The fill buffer is reset as well: a partial window must
   // never surface stale data after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fill <= '0;
         r_hold <= '0;
         r_row  <= '0;
         r_col  <= '0;
         r_push <= 1'b0;
      end else begin
         r_push <= w_last;
         if (flush) begin
            r_row <= '0;
            r_col <= '0;
         end else if (push_in) begin
            if (w_last) begin
               r_hold <= w_win;
               if (slide) begin
                  r_fill <= w_shift;
                  r_row  <= LAST_ROW;
                  r_col  <= '0;
               end else begin
                  r_fill <= w_win;
                  r_row  <= '0;
                  r_col  <= '0;
               end
            end else begin
               r_fill <= w_win;
               if (r_col == LAST_COL) begin
                  r_col <= '0;
                  r_row <= r_row + 3'd1;
               end else begin
                  r_col <= r_col + 3'd1;
               end
            end
         end
      end
   end

   c5x7_wcfg u_wcfg (
      .clk        (clk),
      .reset      (reset),
      .i_h_cw     (h_cw),
      .i_h_ca     (h_ca),
      .i_h_cd     (h_cd),
      .o_cw       (cw),
      .o_ca       (ca),
      .o_cd       (cd),
      .o_drop_cnt (drop_cnt)
   );

   assign push_samp = r_push;

   assign samp00 = r_hold[0][0];
   assign samp01 = r_hold[0][1];
   assign samp02 = r_hold[0][2];
   assign samp03 = r_hold[0][3];
   assign samp04 = r_hold[0][4];
   assign samp10 = r_hold[1][0];
   assign samp11 = r_hold[1][1];
   assign samp12 = r_hold[1][2];
   assign samp13 = r_hold[1][3];
   assign samp14 = r_hold[1][4];
   assign samp20 = r_hold[2][0];
   assign samp21 = r_hold[2][1];
   assign samp22 = r_hold[2][2];
   assign samp23 = r_hold[2][3];
   assign samp24 = r_hold[2][4];
   assign samp30 = r_hold[3][0];
   assign samp31 = r_hold[3][1];
   assign samp32 = r_hold[3][2];
   assign samp33 = r_hold[3][3];
   assign samp34 = r_hold[3][4];
   assign samp40 = r_hold[4][0];
   assign samp41 = r_hold[4][1];
   assign samp42 = r_hold[4][2];
   assign samp43 = r_hold[4][3];
   assign samp44 = r_hold[4][4];
   assign samp50 = r_hold[5][0];
   assign samp51 = r_hold[5][1];
   assign samp52 = r_hold[5][2];
   assign samp53 = r_hold[5][3];
   assign samp54 = r_hold[5][4];
   assign samp60 = r_hold[6][0];
   assign samp61 = r_hold[6][1];
   assign samp62 = r_hold[6][2];
   assign samp63 = r_hold[6][3];
   assign samp64 = r_hold[6][4];
endmodule

// File: doc/c5x7_win_feeder.md
# c5x7_win_feeder

Front-end window assembler for the `c5x7` convolution core. It accepts a serial stream of 40-bit samples and fills a 7-row by 5-column window. It then presents the complete window on the core's 35 sample ports with a single-cycle `push_samp`. Weight writes from the host are registered and aligned onto the core's `ca`/`cd`/`cw` port. The block drives every input of `c5x7` except `clk` and `reset`.

## Interface
- `ROWS`, 7, window rows
- `COLS`, 5, window columns
- `SW`, 40, sample width (signed)
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `push_in`  in  1  sample valid
- `samp_in`  in  40  signed sample
- `slide`  in  1  sampled on window completion: 1 = retain rows 1..6 for the next window
- `flush`  in  1  synchronous abort of the partial window
- `h_cw`  in  1  host weight write strobe
- `h_ca`  in  6  host weight address
- `h_cd`  in  33  host weight data
- `push_samp`  out  1  window valid pulse to the core
- `samp00`..`samp64`  out  40 each  window outputs; `sampRC` is row R (0..6), column C (0..4)
- `cw`  out  1  weight write to the core
- `ca`  out  6  weight address
- `cd`  out  33  weight data
- `drop_cnt`  out  8  count of rejected host writes, saturating

## Operation
- Fill index k runs 0..34. An accepted sample k goes to fill-buffer slot row k/5, column k%5, so k = 5·R + C.
- When k = 34 is accepted:
  - the whole fill buffer, including the sample arriving that cycle, is copied into the output holding registers;
  - `push_samp` is set.
- After the copy:
  - if `slide` = 0: k returns to 0;
  - if `slide` = 1: fill rows 1..6 move to rows 0..5 and k becomes 30, so only 5 new samples complete the next window.
- The output holding registers change only on the copy edge. Between pushes they hold their value.
- `flush`:
  - sets k to 0 and invalidates retained rows;
  - `flush` together with `push_in` on the same cycle: flush wins and the sample is dropped;
  - `flush` on the completing cycle: no push occurs.
- Host writes:
  - `h_ca` in 0..34: registered straight through to `ca`/`cd`/`cw`;
  - `h_ca` greater than 34: dropped, `cw` stays 0 and `drop_cnt` increments;
  - `drop_cnt` saturates at 255.
- When `cw` = 0, `ca` = 0 and `cd` = 0.
- A weight write and `push_samp` on the same cycle is legal and both are issued. The core commits the weight before it computes the window.

## Timing
- Reset values:
  - `push_samp` = 0, `cw` = 0, `ca` = 0, `cd` = 0;
  - all `samp` outputs = 0;
  - `drop_cnt` = 0, k = 0, fill buffer = 0.
- Sample latency: `push_in` with k = 34 at edge N gives `push_samp` high for exactly the cycle following edge N, with the new window valid on all `samp` outputs in that same cycle.
- Weight latency: `h_cw` at edge N gives `cw` high for one cycle after edge N. Window and weight paths have equal latency, so their relative order is preserved.
- Minimum push spacing:
  - 35 cycles with `slide` = 0;
  - 5 cycles with `slide` = 1.
- There is no back-pressure. The core accepts every cycle, so `push_in` is never stalled.
- Every output is a flop output; nothing is combinational from inputs to outputs. This gives hold time on every output after the clock edge.
- An asynchronous `reset` mid-window discards the partial window. No `push_samp` follows reset release until 35 new samples have been accepted.

## Structure
- Package `c5x7_pkg`:
  - constants `ROWS`, `COLS`, `NSAMP` = 35, `SW` = 40, `WAW` = 6, `WDW` = 33, `WMAX` = 34;
  - typedef `samp_t` = logic signed [SW-1:0];
  - typedef `win_t` = samp_t [ROWS-1:0][COLS-1:0].
- Sub-module `c5x7_wcfg`: host-write range check, output register and `drop_cnt`.
- Top level: fill buffer, index counter, slide shifter, holding registers, and the flattening of `win_t` onto the 35 ports.

## Test plan
- Reset release, then samples 1..35 on consecutive cycles with `slide` = 0: one `push_samp`, 36 edges after the first sample; `samp00` = 1, `samp04` = 5, `samp10` = 6, `samp64` = 35; outputs then hold.
- Two back-to-back windows (1..35 then 101..135, `slide` = 0): exactly two pushes, 35 cycles apart; the second window has `samp00` = 101 and `samp64` = 135.
- `slide` = 1 with 1..35 then 36..40: the second push comes 5 cycles after the first; `samp00` = 6, `samp50` = 31, `samp60` = 36, `samp64` = 40.
- `flush` after 20 samples, then 35 new samples 201..235: the only push shows `samp00` = 201; `flush` coincident with the 35th sample gives no push.
- Host writes to address 34 (data 0x1_0000_0001) and to 40: a `cw` pulse with `ca` = 34 and `cd` = 0x100000001 one cycle later; the address-40 write produces no `cw` and `drop_cnt` = 1. A write issued on the completing-sample cycle produces `cw` and `push_samp` together.
- Asynchronous `reset` asserted after 17 samples: all outputs go to 0 immediately; after release, the next push requires a full 35 samples.
